sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, next generation of the team's 16x8 synchronous FIFO.
- Generalised data width and depth.
- Programmable almost-full/almost-empty thresholds.
- Occupancy count output.
- Sticky overflow/underflow error flags.
- Compile-time first-word-fall-through read mode.
Sits between producer and consumer blocks in the same clock domain as a rate-smoothing buffer.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH
(derived) ADDR_W = $clog2(DEPTH); CNT_W = ADDR_W+1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_data  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (rst sampled high on clk edge, synchronous):
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0.
  - full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the first cycle after reset behaves as an empty FIFO.
- Acceptance:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - Both flags are evaluated on register values at the edge; there is no combinational bypass.
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments, wrapping at DEPTH-1 -> 0.
- Read (default mode): on rd_acc, rd_data <= mem[rd_ptr] (1-cycle latency) and rd_ptr increments with wrap. rd_data holds its value when there is no read.
- Count:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Simultaneous events:
  - Full with wr_en & rd_en: read accepted, write rejected (overflow set); count becomes DEPTH-1.
  - Empty with both: write accepted, read rejected (underflow set); count becomes 1.
- Flags: all registered, computed from next count, so they are consistent with count in the same cycle. Never a cycle of stale flags.
- Errors:
  - overflow <= 1 on wr_en & full.
  - underflow <= 1 on rd_en & empty.
  - Flags stay set until clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the set wins.
- Rejected operations: no pointer, memory or count change.
- Legal parameters: AFULL_TH and AEMPTY_TH in 0..DEPTH. Other values are illegal and must be caught by an elaboration-time check.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - rd_data = mem[rd_ptr] combinationally; valid whenever empty=0.
  - rd_en pops the head entry.
  - A word written at edge N appears on rd_data with empty=0 after edge N.
- Not defined: standard mode, registered rd_data with 1-cycle latency after rd_acc.
- Flag, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - function clog2 for ADDR_W/CNT_W;
  - parameter-legality check helpers;
  - localparam defaults DEF_DATA_W=8, DEF_DEPTH=16.
- One sub-module: fifo_ram. Simple dual-port DEPTH x DATA_W array with synchronous write and read, or asynchronous read under FIFO_FWFT_EN. Pointer, count and flag logic stays in the top level.

Test Plan:
- Reset then idle: DEPTH=16, DATA_W=8, no requests -> empty=1, almost_empty=1, full=0, count=0 for 10 cycles.
- Fill/drain: write 0x00..0x0F; full=1 after 16th edge with count=16 and almost_full from count=14. Then read 16 -> rd_data 0x00..0x0F in order, 1 cycle after each rd_en (FWFT: same cycle); empty=1 at the end.
- Overflow and recovery: full, then wr_en=1 with 0xAA -> overflow=1, count stays 16, 0xAA never read. Pulse clr_err -> overflow=0.
- Underflow: empty, then rd_en=1 -> underflow=1, rd_data unchanged, count=0.
- Simultaneous read/write:
  - At count=8: 20 cycles of both -> count stays 8, data order preserved across pointer wrap.
  - At full: both -> count=15, overflow=1.
- Reset mid-operation: count=5, assert rst for 1 cycle -> count=0, empty=1, next write of 0x3C read back as first word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   - clog2():        address/count width derivation
//   - is_pow2(), params_legal(): parameter-legality helpers used at elaboration
//   - DEF_DATA_W, DEF_DEPTH: default geometry
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int unsigned data_w,
                                      input int unsigned depth,
                                      input int unsigned afull_th,
                                      input int unsigned aempty_th);
    return (data_w >= 1) && is_pow2(depth) && (depth >= 4) &&
           (afull_th <= depth) && (aempty_th <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x DATA_W storage for sync_fifo_param.
// Optional feature macro: FIFO_FWFT_EN (asynchronous read; otherwise registered read).
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, clears only the registered read data
//   wr_en    write strobe, wr_addr/wr_data written on the rising edge
//   rd_en    read strobe (registered mode), loads rd_data from rd_addr
//   rd_data  read data: registered (default) or mem[rd_addr] (FIFO_FWFT_EN)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Storage is intentionally not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rd_data = mem[rd_addr];

  // Reset and read strobe have no role with an asynchronous read port.
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rst | rd_en;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count and sticky overflow/underflow flags.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through reads.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, wr_data           write request / data (ignored while full)
//   rd_en, rd_data           read request / data (ignored while empty)
//   full, empty              count == DEPTH / count == 0
//   almost_full              count >= AFULL_TH
//   almost_empty             count <= AEMPTY_TH
//   count                    occupancy 0..DEPTH
//   overflow, underflow      sticky error flags
//   clr_err                  clears error flags (a coincident new error wins)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  localparam int unsigned ADDR_W   = clog2(DEPTH),
  localparam int unsigned CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  if (!params_legal(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_param_check
    $fatal(1, "sync_fifo_param: illegal DATA_W/DEPTH/AFULL_TH/AEMPTY_TH");
  end

  localparam logic [CNT_W-1:0] DepthC  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfullC  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AemptyC = CNT_W'(AEMPTY_TH);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_acc, rd_acc;

  // Acceptance uses registered flags only; a read never frees space for a
  // write in the same cycle.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  // Set has priority over clear.
  always_comb begin
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty_q) begin
      underflow_d = 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q     <= count_d;
      // Flags come from the next count so they never lag count by a cycle.
      full_q      <= (count_d == DepthC);
      empty_q     <= (count_d == '0);
      afull_q     <= (count_d >= AfullC);
      aempty_q    <= (count_d <= AemptyC);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
